// File: rtl/fft_pkg.sv
// Shared FFT constants and the SDF stage sequencer state type.
package fft_pkg;
  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int FFT_TW_W  = FFT_LOG2N - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sdf_state_e;
endpackage

// File: rtl/sdf_stage_ctrl.sv
// Radix-2 SDF stage sequencer: frame counter, FILL/BFLY phase select,
// twiddle index and delay-line flush after the last frame.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             bfly_en,
  output logic             dl_en,
  output logic [LOG2N-2:0] tw_idx,
  output logic             out_valid,
  output logic             out_last,
  output logic             err_frame
);

  localparam logic [LOG2N-1:0] CNT_MAX  = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] HALF_MAX = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

  sdf_state_e       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic             have_prev_q, have_prev_d;
  logic             err_q, err_d;

  logic accept, step, phase, draining;

  assign draining = (state_q == ST_DRAIN);
  assign in_ready = ~draining;
  assign accept   = in_valid & in_ready;
  assign step     = accept | draining;
  assign phase    = cnt_q[LOG2N-1];

  assign dl_en     = step;
  assign bfly_en   = step & phase;
  assign out_valid = step & (phase | have_prev_q);
  // Twiddle applies to the delayed difference, which is emitted in FILL only
  assign tw_idx    = phase ? '0 : cnt_q[LOG2N-2:0];
  assign out_last  = draining & (cnt_q == HALF_MAX);
  assign err_frame = err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    have_prev_d = have_prev_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_last) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (in_last) begin
            cnt_d = '0;
            if (cnt_q == CNT_MAX) begin
              state_d     = ST_DRAIN;
              have_prev_d = 1'b1;
            end else begin
              // Misframed stream: abandon it without flushing
              state_d     = ST_IDLE;
              have_prev_d = 1'b0;
              err_d       = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_MAX) have_prev_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == HALF_MAX) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          have_prev_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        have_prev_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl: directed framing scenarios plus
// randomized traffic against a stream-position reference model.
module tb_sdf_stage_ctrl;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_last;
  logic             in_ready, bfly_en, dl_en, out_valid, out_last, err_frame;
  logic [LOG2N-2:0] tw_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: samples accepted in the current stream, drain progress
  int m_s     = 0;
  bit m_drain = 0;
  int m_k     = 0;
  bit m_err   = 0;

  sdf_stage_ctrl #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .bfly_en(bfly_en), .dl_en(dl_en), .tw_idx(tw_idx),
    .out_valid(out_valid), .out_last(out_last), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic l);
    int  pos;
    bit  ph, acc;
    bit  e_rdy, e_dl, e_bf, e_ov, e_ol;
    int  e_tw;
    @(negedge clk);
    in_valid = v;
    in_last  = l;
    #1;
    pos   = m_s % N;
    ph    = (pos >= N / 2);
    e_rdy = !m_drain;
    acc   = v && e_rdy;
    if (m_drain) begin
      e_dl = 1; e_bf = 0; e_ov = 1; e_tw = m_k; e_ol = (m_k == N / 2 - 1);
    end else begin
      e_dl = acc; e_bf = acc && ph; e_ov = acc && (ph || m_s >= N);
      e_tw = ph ? 0 : pos; e_ol = 0;
    end
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("dl_en", 32'(dl_en), 32'(e_dl));
    chk("bfly_en", 32'(bfly_en), 32'(e_bf));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_last", 32'(out_last), 32'(e_ol));
    chk("tw_idx", 32'(tw_idx), 32'(e_tw));
    chk("err_frame", 32'(err_frame), 32'(m_err));
    if (m_drain) begin
      m_k++;
      if (m_k == N / 2) begin m_drain = 0; m_s = 0; end
    end else if (acc) begin
      if (l) begin
        if (pos == N - 1) begin m_drain = 1; m_k = 0; m_s = 0; end
        else begin m_err = 1; m_s = 0; end
      end else m_s++;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0;
    in_last  = 0;
    #2 rst_n = 0;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst bfly_en", 32'(bfly_en), 32'd0);
    chk("rst dl_en", 32'(dl_en), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst tw_idx", 32'(tw_idx), 32'd0);
    chk("rst err_frame", 32'(err_frame), 32'd0);
    m_s = 0; m_drain = 0; m_k = 0; m_err = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    in_valid = 0;
    in_last  = 0;
    rst_n    = 0;
    #12;
    chk("por in_ready", 32'(in_ready), 32'd1);
    chk("por out_valid", 32'(out_valid), 32'd0);
    chk("por err_frame", 32'(err_frame), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Single frame then drain
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1);
    for (int i = 0; i < N / 2 + 2; i++) cyc(1'b0, 1'b0);

    // Two back-to-back frames, in_valid held high through the drain
    for (int i = 0; i < 2 * N; i++) cyc(1'b1, i == 2 * N - 1);
    for (int i = 0; i < N / 2; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    // Alternating gaps
    for (int i = 0; i < 2 * N; i++) cyc(i % 2 == 0, i == 2 * N - 2);
    for (int i = 0; i < N / 2 + 1; i++) cyc(1'b0, 1'b0);

    // Bad framing: in_last on the sample taken at cnt=5, then a clean frame
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 5);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1);
    for (int i = 0; i < N / 2 + 1; i++) cyc(1'b0, 1'b0);
    // in_last on the very first sample of a stream
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);

    // Reset mid-RUN (also clears sticky error), then mid-DRAIN
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0);
    for (int i = 0; i < N; i++) cyc(1'b1, i == N - 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic v, l;
      v = ($urandom_range(0, 3) != 0);
      l = v && ((((m_s % N) == N - 1) && $urandom_range(0, 2) == 0) ||
                ($urandom_range(0, 59) == 0));
      cyc(v, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
